// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, baud divisor table and transmitter states
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int BAUD_CNT_W = 13;
    localparam int BIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    // Clocks per bit for a baud select; unused codes fall back to the fastest rate.
    function automatic logic [BAUD_CNT_W-1:0] baud_div(input logic [2:0] sel, input int clk_hz);
        case (sel)
            3'd1:    return BAUD_CNT_W'(clk_hz / 57600);
            3'd2:    return BAUD_CNT_W'(clk_hz / 38400);
            3'd3:    return BAUD_CNT_W'(clk_hz / 19200);
            3'd4:    return BAUD_CNT_W'(clk_hz / 9600);
            default: return BAUD_CNT_W'(clk_hz / 115200);
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO buffering bytes ahead of the serialiser
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   sysclk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [7:0]             pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign do_push = push && (count_q != FULL_CNT);
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/uart_send.sv
// rtl/uart_send.sv - buffered 8N1 UART transmitter with selectable baud rate
module uart_send
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [2:0] Baud_set,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    uart_state_e                  state_q, state_d;
    logic [BAUD_CNT_W-1:0]        baud_cnt_q, baud_cnt_d;
    logic [BAUD_CNT_W-1:0]        div_q, div_d;
    logic [BIT_CNT_W-1:0]         bit_idx_q, bit_idx_d;
    logic [7:0]                   shift_q, shift_d;
    logic                         uart_tx_q, uart_tx_d;
    logic                         tx_busy_q, tx_busy_d;
    logic                         tx_done_q, tx_done_d;
    logic                         bit_end, frame_next;
    logic                         fifo_pop, fifo_full, fifo_empty;
    logic [7:0]                   fifo_pop_data;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .sysclk    (sysclk),
        .rst       (rst),
        .push      (tx_valid && tx_ready),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // fifo_full comes straight from the FIFO's count register, so tx_ready has no input path.
    assign tx_ready = !fifo_full;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        div_d      = div_q;
        uart_tx_d  = uart_tx_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
        fifo_pop   = 1'b0;
        frame_next = 1'b0;
        bit_end    = (baud_cnt_q == div_q - BAUD_CNT_W'(1));

        if (state_q != ST_IDLE) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: frame_next = !fifo_empty;
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    uart_tx_d = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        state_d   = ST_STOP;
                        bit_idx_d = '0;
                        uart_tx_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_CNT_W'(1);
                        shift_d   = shift_q >> 1;
                        uart_tx_d = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == BIT_CNT_W'(STOP_BITS - 1)) begin
                        tx_done_d  = 1'b1;
                        frame_next = !fifo_empty;
                        if (fifo_empty) begin
                            state_d   = ST_IDLE;
                            tx_busy_d = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Starting a frame pops the FIFO and freezes the baud rate for the whole frame.
        if (frame_next) begin
            fifo_pop   = 1'b1;
            shift_d    = fifo_pop_data;
            div_d      = baud_div(Baud_set, CLK_HZ);
            baud_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = ST_START;
            uart_tx_d  = 1'b0;
            tx_busy_d  = 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            div_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            uart_tx_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            uart_tx_q  <= uart_tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    fifo_flags_consistent: assert property (@(posedge sysclk) disable iff (rst)
        fifo_empty == (fifo_count == '0));

    assign uart_tx = uart_tx_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule
